// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared states, iteration count and Booth select codes
package mult_pkg;

    localparam int ITER_COUNT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } sel_t;

endpackage

// File: rtl/booth_encoder.sv
// rtl/booth_encoder.sv - radix-4 Booth recoder for one overlapping bit triplet
module booth_encoder
    import mult_pkg::*;
(
    input  logic [2:0] bits,
    output sel_t       sel
);

    always_comb begin
        sel = ZERO;
        case (bits)
            3'b001, 3'b010: sel = PM;
            3'b011:         sel = P2M;
            3'b100:         sel = N2M;
            3'b101, 3'b110: sel = NM;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_radix4.sv
// rtl/booth_mult_radix4.sv - sequential 32x32 signed radix-4 Booth multiplier
module booth_mult_radix4
    import mult_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] mcand;
    logic [66:0] prod;
    sel_t        sel;
    logic [33:0] m;
    logic [33:0] addend;
    logic [33:0] sum;
    logic [66:0] shifted;
    logic [63:0] product;

    booth_encoder u_enc (
        .bits (prod[2:0]),
        .sel  (sel)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_MULT) state_nxt = RUN;
            RUN:     if (cnt == 4'(ITER_COUNT - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator add followed by a 2-bit arithmetic shift of the whole register
    always_comb begin
        m = {{2{mcand[31]}}, mcand};
        addend = '0;
        case (sel)
            PM:      addend = m;
            P2M:     addend = m << 1;
            NM:      addend = -m;
            N2M:     addend = -(m << 1);
            default: addend = '0;
        endcase
        sum     = prod[66:33] + addend;
        shifted = {sum[33], sum[33], sum, prod[32:2]};
        product = prod[64:1];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt            <= '0;
            mcand          <= '0;
            prod           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_MULT) begin
                        mcand <= data_operandA;
                        prod  <= {34'd0, data_operandB, 1'b0};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    prod <= shifted;
                    cnt  <= cnt + 4'd1;
                end
                DONE: begin
                    data_result    <= product[31:0];
                    data_exception <= (product[63:32] != {32{product[31]}});
                    data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_radix4.sv
// tb/tb_booth_mult_radix4.sv - directed self-checking bench for booth_mult_radix4
module tb_booth_mult_radix4;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    booth_mult_radix4 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a multiply from a point just after a rising edge; returns edges until RDY is seen
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, output int cyc);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        cyc = 0;
        while (!data_resultRDY && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    int cyc;
    int pulses;
    logic [31:0] cap;

    initial begin
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick(2);
        check("reset_result", data_result, 32'h0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        run_mult(32'd7, 32'hFFFF_FFFD, cyc);
        check("7x-3_latency", cyc, 32'd17);
        check("7x-3_result", data_result, 32'hFFFF_FFEB);
        check("7x-3_exc", {31'd0, data_exception}, 32'd0);
        check("7x-3_busy_idle", {31'd0, busy}, 32'd0);
        tick(1);
        check("7x-3_rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
        tick(3);
        check("7x-3_hold", data_result, 32'hFFFF_FFEB);

        run_mult(32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("min_x_neg1_latency", cyc, 32'd17);
        check("min_x_neg1_result", data_result, 32'h8000_0000);
        check("min_x_neg1_exc", {31'd0, data_exception}, 32'd1);
        tick(1);

        run_mult(32'h8000_0000, 32'h8000_0000, cyc);
        check("min_x_min_result", data_result, 32'h0000_0000);
        check("min_x_min_exc", {31'd0, data_exception}, 32'd1);
        tick(1);

        run_mult(32'h0001_0000, 32'h0001_0000, cyc);
        check("2p16sq_result", data_result, 32'h0);
        check("2p16sq_exc", {31'd0, data_exception}, 32'd1);
        // Back-to-back: started in the IDLE cycle carrying the previous RDY pulse
        run_mult(32'h0000_FFFF, 32'h0000_FFFF, cyc);
        check("ffffsq_b2b_latency", cyc, 32'd17);
        check("ffffsq_result", data_result, 32'hFFFE_0001);
        check("ffffsq_exc", {31'd0, data_exception}, 32'd1);
        tick(1);

        data_operandA = 32'd5;
        data_operandB = 32'd6;
        ctrl_MULT     = 1'b1;
        tick(1);
        ctrl_MULT = 1'b0;
        tick(5);
        check("midrun_busy", {31'd0, busy}, 32'd1);
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        tick(1);
        ctrl_MULT = 1'b0;
        pulses = 0;
        cap    = '0;
        for (int i = 0; i < 40; i++) begin
            if (data_resultRDY) begin
                pulses++;
                cap = data_result;
            end
            tick(1);
        end
        check("midrun_pulses", pulses, 32'd1);
        check("midrun_result", cap, 32'd30);

        data_operandA = 32'd7;
        data_operandB = 32'd7;
        ctrl_MULT     = 1'b1;
        tick(1);
        ctrl_MULT = 1'b0;
        tick(8);
        reset_n = 1'b0;
        tick(1);
        check("abort_result", data_result, 32'h0);
        check("abort_exc", {31'd0, data_exception}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (data_resultRDY || busy) pulses++;
            tick(1);
        end
        check("abort_no_activity", pulses, 32'd0);

        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        run_mult(32'd2, 32'd3, cyc);
        check("post_reset_latency", cyc, 32'd17);
        check("post_reset_result", data_result, 32'd6);
        check("post_reset_exc", {31'd0, data_exception}, 32'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
